// File: rtl/bus_transfer_arbiter_if.sv
// Signal bundle between the transfer arbiter, its requesters and the bus mux / load enables.
// The master modport is the arbiter's side; slave is the requester/bus side.
interface bus_transfer_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [5*NREQ-1:0] src_flat;
  logic [5*NREQ-1:0] dst_flat;
  logic [4:0]        bus_sel;
  logic [31:0]       dst_ld;
  logic [NREQ-1:0]   ack;
  logic              err;
  logic              busy;
  logic [IDW-1:0]    owner;

  modport master (
    input  req, src_flat, dst_flat,
    output bus_sel, dst_ld, ack, err, busy, owner
  );

  modport slave (
    output req, src_flat, dst_flat,
    input  bus_sel, dst_ld, ack, err, busy, owner
  );
endinterface

// File: rtl/bus_transfer_arbiter.sv
// Round-robin sequencer for register-to-register transfers on the shared datapath bus.
// Optional BUS_ARB_SRC_CHECK_EN: illegal source codes raise err instead of loading zero.
module bus_transfer_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                   clock,
  input  logic                   clear,
  bus_transfer_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, LOAD} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [4:0]      src_q, src_d;
  logic [4:0]      dst_q, dst_d;
  logic [4:0]      bus_sel_q, bus_sel_d;
  logic [31:0]     dst_ld_q, dst_ld_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic [4:0]      src_arr [NREQ];
  logic [4:0]      dst_arr [NREQ];
  logic [IDW-1:0]  ptr_inc;
  logic [IDW-1:0]  arb_start;
  logic [NREQ-1:0] arb_req;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  win_idx;
  logic            win_found;

  // Unpack per-requester source/destination codes.
  for (genvar g = 0; g < NREQ; g++) begin : g_fields
    assign src_arr[g] = bus.src_flat[5*g +: 5];
    assign dst_arr[g] = bus.dst_flat[5*g +: 5];
  end

  assign ptr_inc = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);

  // In LOAD the finishing owner is masked and the search starts just past it.
  always_comb begin
    arb_start = ptr_q;
    arb_req   = bus.req;
    if (state_q == LOAD) begin
      arb_start = ptr_inc;
      arb_req   = bus.req & ~(NREQ'(1) << owner_q);
    end
  end

  // First requesting index at or above arb_start, wrapping around.
  always_comb begin
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(arb_start) + i) % NREQ);
      if (!win_found && arb_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef BUS_ARB_SRC_CHECK_EN
  logic src_illegal;
  assign src_illegal = (src_q == 5'd0) || (src_q >= 5'd24);
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    src_d     = src_q;
    dst_d     = dst_q;
    bus_sel_d = bus_sel_q;
    dst_ld_d  = '0;
    ack_d     = '0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        bus_sel_d = '0;
        busy_d    = 1'b0;
        if (win_found) begin
          state_d   = DRIVE;
          owner_d   = win_idx;
          src_d     = src_arr[win_idx];
          dst_d     = dst_arr[win_idx];
          bus_sel_d = src_arr[win_idx];
          busy_d    = 1'b1;
        end
      end
      DRIVE: begin
        state_d  = LOAD;
        ack_d    = NREQ'(1) << owner_q;
        dst_ld_d = 32'd1 << dst_q;
`ifdef BUS_ARB_SRC_CHECK_EN
        if (src_illegal) begin
          dst_ld_d = '0;
          err_d    = 1'b1;
        end
`endif
      end
      LOAD: begin
        ptr_d = ptr_inc;
        if (win_found) begin
          state_d   = DRIVE;
          owner_d   = win_idx;
          src_d     = src_arr[win_idx];
          dst_d     = dst_arr[win_idx];
          bus_sel_d = src_arr[win_idx];
          busy_d    = 1'b1;
        end else begin
          state_d   = IDLE;
          bus_sel_d = '0;
          busy_d    = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        bus_sel_d = '0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      bus_sel_q <= '0;
      dst_ld_q  <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      bus_sel_q <= bus_sel_d;
      dst_ld_q  <= dst_ld_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.bus_sel = bus_sel_q;
  assign bus.dst_ld  = dst_ld_q;
  assign bus.ack     = ack_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;
  assign bus.owner   = owner_q;

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// Bench for bus_transfer_arbiter: directed vector table, corner sequences, and
// randomized traffic against a transaction-level reference model.
module tb_bus_transfer_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
`ifdef BUS_ARB_SRC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  bus_transfer_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bif ();
  bus_transfer_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clock (clk),
    .clear (clear),
    .bus   (bif)
  );

  int checks = 0;
  int errors = 0;
  bit rnd_on = 1'b0;

  // Reference model: a transfer is "in flight" for two cycles after its grant.
  bit         m_act;
  int         m_age;
  int         m_owner;
  int         m_ptr;
  logic [4:0] m_src;
  logic [4:0] m_dst;

  typedef struct {
    int          idx;
    logic [4:0]  src;
    logic [4:0]  dst;
    bit          chg;
    logic [31:0] ld;
    logic [3:0]  ack;
    bit          err;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_field(input int idx, input logic [4:0] s, input logic [4:0] d);
    bif.src_flat[5*idx +: 5] = s;
    bif.dst_flat[5*idx +: 5] = d;
  endtask

  function automatic bit pick(input logic [NREQ-1:0] r, input int p, output int w);
    w = 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (r[(p + i) % int'(NREQ)]) begin
        w = (p + i) % int'(NREQ);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    logic [NREQ-1:0] r;
    int w;
    r = bif.req;
    if (clear) begin
      m_act = 1'b0; m_age = 0; m_owner = 0; m_ptr = 0;
    end else if (m_act && m_age == 1) begin
      m_age = 2;
    end else begin
      if (m_act) begin
        m_ptr = (m_owner + 1) % int'(NREQ);
        r[m_owner] = 1'b0;
        m_act = 1'b0;
      end
      if (pick(r, m_ptr, w)) begin
        m_act = 1'b1; m_age = 1; m_owner = w;
        m_src = bif.src_flat[5*w +: 5];
        m_dst = bif.dst_flat[5*w +: 5];
      end
    end
  endtask

  task automatic compare_model();
    bit done, legal;
    done  = m_act && (m_age == 2);
    legal = (m_src >= 5'd1) && (m_src <= 5'd23);
    chk("rnd.bus_sel", 32'(bif.bus_sel), m_act ? 32'(m_src) : 32'd0);
    chk("rnd.dst_ld", bif.dst_ld, (done && (legal || !CHK)) ? (32'd1 << m_dst) : 32'd0);
    chk("rnd.ack", 32'(bif.ack), done ? (32'd1 << m_owner) : 32'd0);
    chk("rnd.err", 32'(bif.err), 32'(done && CHK && !legal));
    chk("rnd.busy", 32'(bif.busy), 32'(m_act));
    chk("rnd.owner", 32'(bif.owner), 32'(m_owner));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (rnd_on) compare_model();
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".bus_sel"}, 32'(bif.bus_sel), 32'd0);
    chk({nm, ".dst_ld"}, bif.dst_ld, 32'd0);
    chk({nm, ".ack"}, 32'(bif.ack), 32'd0);
    chk({nm, ".err"}, 32'(bif.err), 32'd0);
    chk({nm, ".busy"}, 32'(bif.busy), 32'd0);
  endtask

  task automatic do_reset();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  int ord [3];

  initial begin
    tbl[0] = '{0, 5'd5,  5'd2,  1'b0, 32'h0000_0004, 4'b0001, 1'b0};
    tbl[1] = '{1, 5'd20, 5'd7,  1'b1, 32'h0000_0080, 4'b0010, 1'b0};
    tbl[2] = '{3, 5'd17, 5'd31, 1'b0, 32'h8000_0000, 4'b1000, 1'b0};
    tbl[3] = '{2, 5'd23, 5'd0,  1'b0, 32'h0000_0001, 4'b0100, 1'b0};
    tbl[4] = '{0, 5'd26, 5'd9,  1'b0, CHK ? 32'h0 : 32'h0000_0200, 4'b0001, CHK};
    tbl[5] = '{1, 5'd0,  5'd4,  1'b0, CHK ? 32'h0 : 32'h0000_0010, 4'b0010, CHK};
    ord = '{0, 1, 3};

    m_act = 1'b0; m_age = 0; m_owner = 0; m_ptr = 0; m_src = '0; m_dst = '0;
    bif.req = '0; bif.src_flat = '0; bif.dst_flat = '0;
    clear = 1'b1;
    tick();
    tick();
    chk_idle("reset");
    chk("reset.owner", 32'(bif.owner), 32'd0);
    clear = 1'b0;
    tick();

    // Single transfers from IDLE, one table row each.
    for (int i = 0; i < 6; i++) begin
      bif.req = 4'd1 << tbl[i].idx;
      set_field(tbl[i].idx, tbl[i].src, tbl[i].dst);
      tick();
      chk("vec.grant_sel", 32'(bif.bus_sel), 32'(tbl[i].src));
      chk("vec.grant_busy", 32'(bif.busy), 32'd1);
      chk("vec.grant_owner", 32'(bif.owner), 32'(tbl[i].idx));
      chk("vec.grant_ack", 32'(bif.ack), 32'd0);
      if (tbl[i].chg) set_field(tbl[i].idx, 5'd3, 5'd1);
      tick();
      chk("vec.load_sel", 32'(bif.bus_sel), 32'(tbl[i].src));
      chk("vec.load_dst_ld", bif.dst_ld, tbl[i].ld);
      chk("vec.load_ack", 32'(bif.ack), 32'(tbl[i].ack));
      chk("vec.load_err", 32'(bif.err), 32'(tbl[i].err));
      bif.req = '0;
      tick();
      chk_idle("vec.after");
    end

    // Contention: requesters 0, 1, 3 held continuously from pointer 0.
    do_reset();
    for (int i = 0; i < 4; i++) set_field(i, 5'(i + 1), 5'(i + 10));
    bif.req = 4'b1011;
    tick();
    chk("rr.first_owner", 32'(bif.owner), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr.ack", 32'(bif.ack), 32'd1 << ord[k % 3]);
      chk("rr.dst_ld", bif.dst_ld, 32'd1 << (ord[k % 3] + 10));
      tick();
      chk("rr.next_owner", 32'(bif.owner), 32'(ord[(k + 1) % 3]));
      chk("rr.busy", 32'(bif.busy), 32'd1);
      chk("rr.bus_sel", 32'(bif.bus_sel), 32'(ord[(k + 1) % 3] + 1));
    end
    bif.req = '0;
    repeat (4) tick();
    chk_idle("rr.drain");

    // Owner masking: the finishing requester keeps req high past its ack.
    bif.req = 4'b0100;
    tick();
    chk("mask.owner", 32'(bif.owner), 32'd2);
    tick();
    chk("mask.ack", 32'(bif.ack), 32'b0100);
    tick();
    chk("mask.busy_idle", 32'(bif.busy), 32'd0);
    chk("mask.sel_idle", 32'(bif.bus_sel), 32'd0);
    chk("mask.no_ack", 32'(bif.ack), 32'd0);
    tick();
    chk("mask.regrant_busy", 32'(bif.busy), 32'd1);
    chk("mask.regrant_owner", 32'(bif.owner), 32'd2);
    tick();
    chk("mask.reack", 32'(bif.ack), 32'b0100);
    bif.req = '0;
    tick();
    chk_idle("mask.after");

    // Clear in DRIVE aborts the transfer; a fresh request then runs normally.
    bif.req = 4'b0001;
    set_field(0, 5'd5, 5'd2);
    tick();
    chk("clr.granted", 32'(bif.busy), 32'd1);
    clear = 1'b1;
    bif.req = 4'b1000;
    set_field(3, 5'd22, 5'd3);
    tick();
    chk_idle("clr.abort");
    chk("clr.owner", 32'(bif.owner), 32'd0);
    tick();
    chk_idle("clr.held");
    clear = 1'b0;
    tick();
    chk("clr.owner3", 32'(bif.owner), 32'd3);
    chk("clr.sel3", 32'(bif.bus_sel), 32'd22);
    chk("clr.ack_early", 32'(bif.ack), 32'd0);
    tick();
    chk("clr.ack3", 32'(bif.ack), 32'b1000);
    chk("clr.dst_ld3", bif.dst_ld, 32'h8);
    bif.req = '0;
    tick();
    chk_idle("clr.after");

    // Randomized traffic against the reference model.
    do_reset();
    rnd_on = 1'b1;
    repeat (3000) begin
      bif.req      = 4'($urandom);
      bif.src_flat = 20'($urandom);
      bif.dst_flat = 20'($urandom);
      clear        = ($urandom_range(0, 63) == 0);
      tick();
    end
    rnd_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
